bram_debug_sequencer: RTL and testbench
=======================================

Name: bram_debug_sequencer

Overview:
Synthesizable multi-channel controller driving the RV32Core BRAM debug ports (A2/WD2/WE2/RD2). It streams preload words into a selected BRAM, streams the BRAM contents back out, and issues a timed CPU reset pulse, all under a command handshake. It sits between a host link (UART/JTAG bridge, or a bench driver) and the core's debug ports, so memories can be loaded and dumped without simulation-only file I/O.

Parameters:
CHANNELS, 2, number of BRAMs served; channel 0 = DataRAM, 1 = InstRAM
WORDS, 4096, 32-bit words per BRAM
RD_LATENCY, 1, cycles from A2 change to valid RD2, range 1..4
RST_CYCLES, 5, cycles CPU_RST_OUT is held high by an RST command

Ports:
CPU_CLK  in  1  clock; all logic on rising edge
CPU_RST  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&&ready
cmd_op  in  2  0=LOAD, 1=DUMP, 2=RST, 3=reserved
cmd_chan  in  clog2(CHANNELS) max 1  target channel
cmd_count  in  13  words to transfer
in_valid / in_ready  in / out  1  load-data handshake
in_data  in  32  load word
in_last  in  1  marks final load word
out_valid / out_ready  out / in  1  dump-data handshake
out_addr  out  32  byte address of dumped word
out_data  out  32  dumped word
dbg_a2  out  32*CHANNELS  per-channel debug address (byte, word aligned)
dbg_wd2  out  32*CHANNELS  per-channel write data
dbg_we2  out  4*CHANNELS  per-channel byte write enables
dbg_rd2  in  32*CHANNELS  per-channel read data
CPU_RST_OUT  out  1  active-high reset to RV32Core
busy  out  1  high in any non-IDLE state
cmd_err  out  1  one-cycle pulse on rejected command

Behaviour:
- Reset (CPU_RST=0, async): state IDLE; cmd_ready=1; in_ready, out_valid, busy, cmd_err, CPU_RST_OUT = 0; all dbg_a2, dbg_wd2, out_addr, out_data = 0; dbg_we2 = 0. Reset mid-transfer aborts immediately; no further WE asserted.
- States: IDLE, LOAD, DUMP_ADDR, DUMP_WAIT, DUMP_OUT, RSTP.
- IDLE: cmd_ready=1. On accept: reject (cmd_err pulse next cycle, stay IDLE) if op=3, cmd_chan>=CHANNELS, or cmd_count>WORDS. count=0 for LOAD/DUMP: accepted, no memory access, stays IDLE. Otherwise go to LOAD/DUMP_ADDR/RSTP; index i=0.
- LOAD: in_ready=1. Each in_valid&&in_ready: selected channel gets dbg_a2=4*i, dbg_wd2=in_data, dbg_we2=4'hF for exactly that one cycle (registered, write lands the following edge); i++. Exit to IDLE after the word where i+1==count or in_last=1, whichever first. Non-selected channels: we2=0 always. in_valid low: we2=0, i holds.
- DUMP_ADDR: dbg_a2[chan]=4*i, we2=0, then DUMP_WAIT for RD_LATENCY cycles, then capture dbg_rd2[chan] into out_data, out_addr=4*i, out_valid=1 (DUMP_OUT).
- DUMP_OUT: out_data/out_addr stable while out_valid&&!out_ready. On out_ready: out_valid drops, i++; if i==count go IDLE else DUMP_ADDR. Throughput: one word per RD_LATENCY+2 cycles minimum.
- RSTP: CPU_RST_OUT=1 for exactly RST_CYCLES cycles, then 0, back to IDLE. Counter 3-bit min, width from RST_CYCLES.
- cmd_ready=0 in every non-IDLE state; commands offered then are held by the sender, not dropped.
- Address arithmetic: 32-bit, i zero-extended, shifted left 2; never exceeds 4*(WORDS-1).
- busy = (state != IDLE).

Test Plan:
- LOAD ch0 count=3, data 0x11,0x22,0x33 with in_valid gaps -> three single-cycle we2[3:0]=F at a2 0x0,0x4,0x8; no WE during gaps; busy clears after third word.
- LOAD ch1 count=8, in_last on 2nd word 0xDEAD -> writes at 0x0,0x4 on ch1 only, ch0 we2=0 throughout, return IDLE.
- DUMP ch0 count=3 after first test, RD_LATENCY=2, out_ready low 5 cycles on word 1 -> (0x0,0x11),(0x4,0x22),(0x8,0x33); word 1 held stable while stalled.
- RST command -> CPU_RST_OUT high exactly 5 cycles, cmd_ready low for the same window.
- cmd_count=4097, cmd_chan=2, op=3 -> each gives one cmd_err pulse, no WE, state IDLE.
- Assert CPU_RST low mid-DUMP -> out_valid, we2, busy all 0 asynchronously; new LOAD accepted after release.

Source files
------------

// File: rtl/bram_debug_sequencer.sv
// Host-driven loader/dumper for the RV32Core BRAM debug ports.
// Also issues a timed CPU reset pulse; one command at a time.
module bram_debug_sequencer #(
  parameter int CHANNELS   = 2,
  parameter int WORDS      = 4096,
  parameter int RD_LATENCY = 1,
  parameter int RST_CYCLES = 5,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    CPU_CLK,
  input  logic                    CPU_RST,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [CW-1:0]           cmd_chan,
  input  logic [12:0]             cmd_count,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_addr,
  output logic [31:0]             out_data,
  output logic [32*CHANNELS-1:0]  dbg_a2,
  output logic [32*CHANNELS-1:0]  dbg_wd2,
  output logic [4*CHANNELS-1:0]   dbg_we2,
  input  logic [32*CHANNELS-1:0]  dbg_rd2,
  output logic                    CPU_RST_OUT,
  output logic                    busy,
  output logic                    cmd_err
);

  localparam int RC = $clog2(RST_CYCLES + 1);
  localparam int RW = (RC > 3) ? RC : 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DUMP_ADDR,
    DUMP_WAIT,
    DUMP_OUT,
    RSTP
  } state_t;

  state_t state;
  state_t nextState;

  logic [CW-1:0] chanQ;
  logic [12:0]   countQ;
  logic [12:0]   idx;
  logic [2:0]    waitCnt;
  logic [RW-1:0] rstCnt;
  logic [31:0]   a2Q [CHANNELS];
  logic [31:0]   wdQ [CHANNELS];
  logic [3:0]    weQ [CHANNELS];
  logic [31:0]   outAddrQ;
  logic [31:0]   outDataQ;
  logic          errQ;
  logic [31:0]   rdSel;

  logic accept;
  logic bad;
  logic start;
  logic beat;
  logic lastBeat;
  logic rdDone;
  logic popOut;
  logic lastIdx;

  function automatic logic [31:0] wordAddr(input logic [12:0] i);
    return {17'd0, i, 2'b00};
  endfunction

  assign accept   = cmd_valid && (state == IDLE);
  assign bad      = (cmd_op == 2'd3)
                 || (32'(cmd_chan) >= CHANNELS)
                 || (32'(cmd_count) > WORDS);
  assign start    = accept && !bad
                 && ((cmd_op == 2'd2) || (cmd_count != 13'd0));
  assign lastIdx  = (idx + 13'd1) == countQ;
  assign beat     = (state == LOAD) && in_valid;
  assign lastBeat = beat && (lastIdx || in_last);
  assign rdDone   = (state == DUMP_WAIT)
                 && (waitCnt == 3'(RD_LATENCY - 1));
  assign popOut   = (state == DUMP_OUT) && out_ready;
  assign rdSel    = dbg_rd2[int'(chanQ)*32 +: 32];

  always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
    if (!CPU_RST) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          unique case (cmd_op)
            2'd0:    nextState = LOAD;
            2'd1:    nextState = DUMP_ADDR;
            default: nextState = RSTP;
          endcase
        end
      end
      LOAD:      if (lastBeat) nextState = IDLE;
      DUMP_ADDR: nextState = DUMP_WAIT;
      DUMP_WAIT: if (rdDone) nextState = DUMP_OUT;
      DUMP_OUT: begin
        if (popOut) nextState = lastIdx ? IDLE : DUMP_ADDR;
      end
      RSTP: begin
        if (rstCnt == RW'(RST_CYCLES - 1)) nextState = IDLE;
      end
      default:   nextState = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = (state == IDLE);
    in_ready    = (state == LOAD);
    out_valid   = (state == DUMP_OUT);
    busy        = (state != IDLE);
    CPU_RST_OUT = (state == RSTP);
    cmd_err     = errQ;
    out_addr    = outAddrQ;
    out_data    = outDataQ;
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
    if (!CPU_RST) begin
      chanQ    <= '0;
      countQ   <= '0;
      idx      <= '0;
      waitCnt  <= '0;
      rstCnt   <= '0;
      outAddrQ <= '0;
      outDataQ <= '0;
      errQ     <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        a2Q[c] <= '0;
        wdQ[c] <= '0;
        weQ[c] <= '0;
      end
    end else begin
      errQ <= accept && bad;
      for (int c = 0; c < CHANNELS; c++) weQ[c] <= '0;
      if (start) begin
        chanQ  <= cmd_chan;
        countQ <= cmd_count;
        idx    <= '0;
      end
      if (start && (cmd_op == 2'd1)) a2Q[cmd_chan] <= '0;
      // Write strobe is registered: the BRAM commits on the next edge.
      if (beat) begin
        a2Q[chanQ] <= wordAddr(idx);
        wdQ[chanQ] <= in_data;
        weQ[chanQ] <= 4'hF;
        idx        <= idx + 13'd1;
      end
      if (state == DUMP_WAIT) waitCnt <= waitCnt + 3'd1;
      else                    waitCnt <= '0;
      if (rdDone) begin
        outDataQ <= rdSel;
        outAddrQ <= wordAddr(idx);
      end
      // Present the next address on entry to DUMP_ADDR.
      if (popOut) begin
        idx <= idx + 13'd1;
        if (!lastIdx) a2Q[chanQ] <= wordAddr(idx + 13'd1);
      end
      if (state == RSTP) rstCnt <= rstCnt + RW'(1);
      else               rstCnt <= '0;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : gFlat
    assign dbg_a2[g*32 +: 32] = a2Q[g];
    assign dbg_wd2[g*32 +: 32] = wdQ[g];
    assign dbg_we2[g*4 +: 4]  = weQ[g];
  end

endmodule

// File: tb/tb_bram_debug_sequencer.sv
// Bench for bram_debug_sequencer with a 3-channel BRAM model.
// Write and dump expectations are queued at stimulus time.
module tb_bram_debug_sequencer;

  localparam int NCH = 3;
  localparam int LAT = 2;

  logic              clk = 1'b0;
  logic              CPU_RST;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [1:0]        cmd_chan;
  logic [12:0]       cmd_count;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_addr;
  logic [31:0]       out_data;
  logic [32*NCH-1:0] dbg_a2;
  logic [32*NCH-1:0] dbg_wd2;
  logic [4*NCH-1:0]  dbg_we2;
  logic [32*NCH-1:0] dbg_rd2;
  logic              CPU_RST_OUT;
  logic              busy;
  logic              cmd_err;

  always #5 clk = ~clk;

  bram_debug_sequencer #(
    .CHANNELS(NCH),
    .WORDS(4096),
    .RD_LATENCY(LAT),
    .RST_CYCLES(5)
  ) dut (
    .CPU_CLK(clk),
    .CPU_RST(CPU_RST),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_chan(cmd_chan),
    .cmd_count(cmd_count),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr(out_addr),
    .out_data(out_data),
    .dbg_a2(dbg_a2),
    .dbg_wd2(dbg_wd2),
    .dbg_we2(dbg_we2),
    .dbg_rd2(dbg_rd2),
    .CPU_RST_OUT(CPU_RST_OUT),
    .busy(busy),
    .cmd_err(cmd_err)
  );

  typedef struct {
    int          chan;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } rd_t;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  chan;
    logic [12:0] count;
    logic        expErr;
  } cmdVec_t;

  wr_t wq[$];
  rd_t dq[$];
  int  nChecks = 0;
  int  nErrors = 0;

  logic [31:0] mem  [NCH][16];
  logic [31:0] rdP1 [NCH];
  logic [31:0] rdP2 [NCH];

  initial begin
    for (int c = 0; c < NCH; c++) begin
      rdP1[c] = '0;
      rdP2[c] = '0;
      for (int w = 0; w < 16; w++) mem[c][w] = '0;
    end
  end

  // BRAM model: byte-enabled write, LAT-cycle registered read.
  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      for (int b = 0; b < 4; b++)
        if (dbg_we2[c*4+b])
          mem[c][dbg_a2[c*32+2 +: 4]][b*8 +: 8] <= dbg_wd2[c*32+b*8 +: 8];
      rdP1[c] <= mem[c][dbg_a2[c*32+2 +: 4]];
      rdP2[c] <= rdP1[c];
    end
  end

  always_comb begin
    dbg_rd2 = '0;
    for (int c = 0; c < NCH; c++) dbg_rd2[c*32 +: 32] = rdP2[c];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (CPU_RST) begin
      for (int c = 0; c < NCH; c++) begin
        if (dbg_we2[c*4 +: 4] != 4'h0) begin
          if (wq.size() == 0) begin
            nChecks++;
            nErrors++;
            $display("FAIL unexpected_we: chan %0d addr %h",
                     c, dbg_a2[c*32 +: 32]);
          end else begin
            e = wq.pop_front();
            chk("we_chan", 32'(c), 32'(e.chan));
            chk("we_mask", 32'(dbg_we2[c*4 +: 4]), 32'hF);
            chk("we_addr", dbg_a2[c*32 +: 32], e.addr);
            chk("we_data", dbg_wd2[c*32 +: 32], e.data);
          end
        end
      end
    end
  end

  task automatic sendCmd(input logic [1:0] op, input logic [1:0] ch,
                         input logic [12:0] cnt);
    int t = 0;
    cmd_op    = op;
    cmd_chan  = ch;
    cmd_count = cnt;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      nChecks++;
      nErrors++;
      $display("FAIL cmd_accept: got timeout expected cmd_ready");
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic sendWord(input int ch, input int i,
                          input logic [31:0] d, input logic last);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      nChecks++;
      nErrors++;
      $display("FAIL in_ready: got timeout expected 1");
    end else begin
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      wq.push_back('{ch, 32'(i) << 2, d});
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic waitOut(output int t);
    t = 0;
    while (!out_valid && t < 30) begin
      @(negedge clk);
      t++;
    end
  endtask

  initial begin
    cmdVec_t     vecs [6];
    rd_t         r;
    int          t;
    int          hi;
    logic [31:0] holdA;
    logic [31:0] holdD;

    vecs[0] = '{2'd3, 2'd0, 13'd1,    1'b1};
    vecs[1] = '{2'd0, 2'd3, 13'd1,    1'b1};
    vecs[2] = '{2'd0, 2'd0, 13'd4097, 1'b1};
    vecs[3] = '{2'd2, 2'd3, 13'd0,    1'b1};
    vecs[4] = '{2'd1, 2'd0, 13'd0,    1'b0};
    vecs[5] = '{2'd0, 2'd2, 13'd0,    1'b0};

    CPU_RST   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_chan  = '0;
    cmd_count = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_err", 32'(cmd_err), 32'd0);
    chk("rst_cpu_rst", 32'(CPU_RST_OUT), 32'd0);
    chk("rst_a2", 32'(|dbg_a2), 32'd0);
    chk("rst_wd2", 32'(|dbg_wd2), 32'd0);
    chk("rst_we2", 32'(|dbg_we2), 32'd0);
    chk("rst_out", out_addr | out_data, 32'd0);
    CPU_RST = 1'b1;
    @(negedge clk);

    // LOAD ch0, three words with gaps
    sendCmd(2'd0, 2'd0, 13'd3);
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_in_ready", 32'(in_ready), 32'd1);
    chk("load_cmd_ready", 32'(cmd_ready), 32'd0);
    sendWord(0, 0, 32'h11, 1'b0);
    repeat (2) @(negedge clk);
    sendWord(0, 1, 32'h22, 1'b0);
    @(negedge clk);
    sendWord(0, 2, 32'h33, 1'b0);
    chk("load_done_busy", 32'(busy), 32'd0);

    // LOAD ch1 count 8 cut short by in_last
    sendCmd(2'd0, 2'd1, 13'd8);
    sendWord(1, 0, 32'hBEEF, 1'b0);
    sendWord(1, 1, 32'hDEAD, 1'b1);
    chk("last_busy", 32'(busy), 32'd0);
    chk("last_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("mem1_0", mem[1][0], 32'hBEEF);
    chk("mem1_1", mem[1][1], 32'hDEAD);
    chk("mem0_2", mem[0][2], 32'h33);
    chk("wq_empty_load", 32'(wq.size()), 32'd0);

    // DUMP ch0, stall on word 1
    dq.push_back('{32'h0, 32'h11});
    dq.push_back('{32'h4, 32'h22});
    dq.push_back('{32'h8, 32'h33});
    sendCmd(2'd1, 2'd0, 13'd3);
    for (int k = 0; k < 3; k++) begin
      waitOut(t);
      chk("dump_gap", 32'(t), 32'(LAT + 1));
      if (k == 1) begin
        holdA = out_addr;
        holdD = out_data;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_addr", out_addr, holdA);
          chk("stall_data", out_data, holdD);
        end
      end
      if (dq.size() != 0) begin
        r = dq.pop_front();
        chk("dump_addr", out_addr, r.addr);
        chk("dump_data", out_data, r.data);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("dump_valid_drop", 32'(out_valid), 32'd0);
    end
    chk("dump_done_busy", 32'(busy), 32'd0);

    // RST pulse width
    sendCmd(2'd2, 2'd0, 13'd0);
    hi = 0;
    t  = 0;
    while (CPU_RST_OUT && t < 20) begin
      chk("rstp_cmd_ready", 32'(cmd_ready), 32'd0);
      hi++;
      t++;
      @(negedge clk);
    end
    chk("rstp_width", 32'(hi), 32'd5);
    chk("rstp_ready_back", 32'(cmd_ready), 32'd1);

    // Rejected and zero-count commands
    for (int v = 0; v < 6; v++) begin
      sendCmd(vecs[v].op, vecs[v].chan, vecs[v].count);
      chk($sformatf("vec%0d_err", v), 32'(cmd_err), 32'(vecs[v].expErr));
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
      chk($sformatf("vec%0d_ready", v), 32'(cmd_ready), 32'd1);
      @(negedge clk);
      chk($sformatf("vec%0d_err_pulse", v), 32'(cmd_err), 32'd0);
    end

    // Async reset in the middle of a DUMP
    sendCmd(2'd1, 2'd0, 13'd3);
    waitOut(t);
    chk("abort_reached_out", 32'(out_valid), 32'd1);
    #1 CPU_RST = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_we2", 32'(|dbg_we2), 32'd0);
    chk("abort_a2", 32'(|dbg_a2), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    CPU_RST = 1'b1;
    @(negedge clk);
    sendCmd(2'd0, 2'd2, 13'd1);
    chk("reload_busy", 32'(busy), 32'd1);
    sendWord(2, 0, 32'hCAFE, 1'b0);
    chk("reload_done", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("mem2_0", mem[2][0], 32'hCAFE);
    chk("wq_empty_end", 32'(wq.size()), 32'd0);
    chk("dq_empty_end", 32'(dq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
